mc_control_fsm: RTL and testbench
=================================

// Module: mc_control_fsm
// PURPOSE
//  Main control FSM for the multicycle RV32I datapath. Moore state machine plus
//  combinational ALU/immediate decoders. Its 2-bit selects drive the datapath's
//  4:1 select muxes: alu_src_a, alu_src_b and result_src. Memory accesses stall
//  on a ready handshake.
// PARAMETERS
//  (none; encodings are fixed by the datapath)
// PORTS
//  clk          in   1  system clock, rising edge
//  rst_n        in   1  asynchronous active-low reset
//  op           in   7  instr[6:0] from IR
//  funct3       in   3  instr[14:12]
//  funct7b5     in   1  instr[30]
//  zero         in   1  ALU zero flag (same cycle)
//  mem_ready    in   1  memory has completed the current access this cycle
//  pc_write     out  1  PC register load enable
//  ir_write     out  1  IR/OldPC load enable
//  reg_write    out  1  register file write enable
//  mem_write    out  1  data memory write request
//  adr_src      out  1  0 = PC, 1 = ALUOut onto memory address
//  alu_src_a    out  2  00 PC, 01 OldPC, 10 RD1, 11 unused (0)
//  alu_src_b    out  2  00 RD2, 01 ImmExt, 10 const 4, 11 unused (0)
//  result_src   out  2  00 ALUOut, 01 Data, 10 ALUResult, 11 unused (0)
//  imm_src      out  2  00 I, 01 S, 10 B, 11 J (from op, combinational)
//  alu_control  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt
//  illegal_op   out  1  1-cycle pulse in DECODE for an unsupported op/funct3
// BEHAVIOUR
//  - The state register is async-cleared to FETCH.
//  - While rst_n=0, all outputs are forced to 0, except imm_src, which stays a pure decode.
//  - Outputs are a function of state only. Exceptions: pc_write, which uses zero,
//    funct3 and mem_ready, and the mem_ready gating below.
//  - Unlisted selects are 00.
//  - Opcodes: lw 0000011, sw 0100011, R 0110011, I-ALU 0010011, B 1100011, jal 1101111.
//  - States and transitions:
//    FETCH: adr_src=0, a=00, b=10, alu_op=add, result_src=10.
//      ir_write=pc_write=mem_ready. Stay in FETCH until mem_ready=1, then DECODE.
//    DECODE: a=01, b=01, add (branch target into ALUOut). Next state by op:
//      lw/sw -> MEMADR; R -> EXECR; I-ALU -> EXECI; B -> BRANCH; jal -> JAL.
//      Any other op, or B with funct3 not 000/001: illegal_op=1, next FETCH.
//    MEMADR: a=10, b=01, add. lw -> MEMREAD; sw -> MEMWRITE.
//    MEMREAD: adr_src=1, result_src=00. Hold until mem_ready, then MEMWB.
//    MEMWB: result_src=01, reg_write=1. Next FETCH.
//    MEMWRITE: adr_src=1, result_src=00, mem_write=1 while in state.
//      Hold until mem_ready, then FETCH.
//    EXECR: a=10, b=00, alu_op=funct. Next ALUWB.
//    EXECI: a=10, b=01, alu_op=funct. Next ALUWB.
//    ALUWB: result_src=00, reg_write=1. Next FETCH.
//    JAL: a=01, b=10, add, result_src=00, pc_write=1. Next ALUWB.
//    BRANCH: a=10, b=00, sub, result_src=00, pc_write=zero^funct3[0]. Next FETCH.
//  - ALU decode:
//    - alu_op add -> 000; sub -> 001.
//    - funct, by funct3:
//      - 000: sub if op[5]&funct7b5, else add.
//      - 010: slt.
//      - 110: or.
//      - 111: and.
//      - others: add.
//  - imm_src decode: sw -> 01, B -> 10, jal -> 11, else 00.
//  - Latency (mem_ready=1 throughout): lw 5, sw 4, R/I 4, jal 4, branch 3 cycles.
//  - Stalls: mem_ready=0 holds the state and all selects stable; strobes gated
//    by mem_ready stay low.
//  - Reset mid-instruction: immediate return to FETCH, all strobes low.
//    No write completes after reset assertion.
//  - Unreachable state encoding -> FETCH.
// TESTING
//  1. Reset: rst_n=0 mid-MEMWRITE -> same cycle mem_write=0. Release -> FETCH;
//     with mem_ready=1, ir_write=pc_write=1 and next state DECODE.
//  2. lw (op=0000011), mem_ready tied 1 -> FETCH,DECODE,MEMADR,MEMREAD,MEMWB.
//     reg_write=1 with result_src=01 only in cycle 5.
//  3. sw, mem_ready low for 3 cycles in MEMWRITE -> mem_write=1 for 4 cycles,
//     adr_src=1 throughout, then FETCH.
//  4. beq: zero=1 -> pc_write=1 in BRANCH. bne (funct3=001): zero=1 -> pc_write=0.
//     funct3=100 -> illegal_op pulse in DECODE, then FETCH.
//  5. R-type sub (funct3=000, funct7b5=1) in EXECR -> alu_control=001, a=10, b=00.
//     addi with funct7b5=1 -> alu_control=000.
//  6. jal -> JAL cycle: a=01, b=10, pc_write=1. Then ALUWB: reg_write=1, result_src=00.

Source files
------------

// File: rtl/mc_control_fsm.sv
// rtl/mc_control_fsm.sv - main control FSM for the multicycle RV32I datapath
// Moore state register plus combinational select, ALU and immediate decoders.
module mc_control_fsm (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       ir_write,
  output logic       reg_write,
  output logic       mem_write,
  output logic       adr_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] result_src,
  output logic [1:0] imm_src,
  output logic [2:0] alu_control,
  output logic       illegal_op
);

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_B   = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_JAL      = 4'd9,
    S_BRANCH   = 4'd10
  } state_t;

  typedef enum logic [1:0] {
    ALU_ADD   = 2'd0,
    ALU_SUB   = 2'd1,
    ALU_FUNCT = 2'd2
  } alu_op_t;

  state_t  state;
  alu_op_t alu_op;
  logic    branch_ok;
  logic    op_known;

  // Only beq/bne are supported among the branch encodings.
  assign branch_ok = (funct3[2:1] == 2'b00);

  always_comb begin
    op_known = 1'b0;
    case (op)
      OP_LW, OP_SW, OP_R, OP_I, OP_B, OP_JAL: op_known = 1'b1;
      default:                                op_known = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_FETCH;
    end else begin
      case (state)
        S_FETCH:    if (mem_ready) state <= S_DECODE;
        S_DECODE: begin
          case (op)
            OP_LW, OP_SW: state <= S_MEMADR;
            OP_R:         state <= S_EXECR;
            OP_I:         state <= S_EXECI;
            OP_B:         state <= branch_ok ? S_BRANCH : S_FETCH;
            OP_JAL:       state <= S_JAL;
            default:      state <= S_FETCH;
          endcase
        end
        S_MEMADR:   state <= (op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
        S_MEMREAD:  if (mem_ready) state <= S_MEMWB;
        S_MEMWB:    state <= S_FETCH;
        S_MEMWRITE: if (mem_ready) state <= S_FETCH;
        S_EXECR:    state <= S_ALUWB;
        S_EXECI:    state <= S_ALUWB;
        S_ALUWB:    state <= S_FETCH;
        S_JAL:      state <= S_ALUWB;
        S_BRANCH:   state <= S_FETCH;
        default:    state <= S_FETCH;
      endcase
    end
  end

  always_comb begin
    pc_write    = 1'b0;
    ir_write    = 1'b0;
    reg_write   = 1'b0;
    mem_write   = 1'b0;
    adr_src     = 1'b0;
    alu_src_a   = 2'b00;
    alu_src_b   = 2'b00;
    result_src  = 2'b00;
    alu_op      = ALU_ADD;
    illegal_op  = 1'b0;
    alu_control = 3'b000;

    case (state)
      S_FETCH: begin
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        ir_write   = mem_ready;
        pc_write   = mem_ready;
      end
      S_DECODE: begin
        alu_src_a  = 2'b01;
        alu_src_b  = 2'b01;
        illegal_op = !op_known || ((op == OP_B) && !branch_ok);
      end
      S_MEMADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
      end
      S_MEMREAD:  adr_src = 1'b1;
      S_MEMWB: begin
        result_src = 2'b01;
        reg_write  = 1'b1;
      end
      S_MEMWRITE: begin
        adr_src   = 1'b1;
        mem_write = 1'b1;
      end
      S_EXECR: begin
        alu_src_a = 2'b10;
        alu_op    = ALU_FUNCT;
      end
      S_EXECI: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        alu_op    = ALU_FUNCT;
      end
      S_ALUWB:    reg_write = 1'b1;
      S_JAL: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        pc_write  = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a = 2'b10;
        alu_op    = ALU_SUB;
        pc_write  = zero ^ funct3[0];
      end
      default: ;
    endcase

    case (alu_op)
      ALU_ADD: alu_control = 3'b000;
      ALU_SUB: alu_control = 3'b001;
      default: begin
        case (funct3)
          3'b000:  alu_control = (op[5] && funct7b5) ? 3'b001 : 3'b000;
          3'b010:  alu_control = 3'b101;
          3'b110:  alu_control = 3'b011;
          3'b111:  alu_control = 3'b010;
          default: alu_control = 3'b000;
        endcase
      end
    endcase

    // Reset kills every strobe and select in the same cycle it is asserted.
    if (!rst_n) begin
      pc_write    = 1'b0;
      ir_write    = 1'b0;
      reg_write   = 1'b0;
      mem_write   = 1'b0;
      adr_src     = 1'b0;
      alu_src_a   = 2'b00;
      alu_src_b   = 2'b00;
      result_src  = 2'b00;
      alu_control = 3'b000;
      illegal_op  = 1'b0;
    end
  end

  always_comb begin
    imm_src = 2'b00;
    case (op)
      OP_SW:   imm_src = 2'b01;
      OP_B:    imm_src = 2'b10;
      OP_JAL:  imm_src = 2'b11;
      default: imm_src = 2'b00;
    endcase
  end

endmodule

// File: tb/tb_mc_control_fsm.sv
// tb/tb_mc_control_fsm.sv - randomized instruction-stream bench for mc_control_fsm
module tb_mc_control_fsm;

  logic       clk;
  logic       rst_n;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       zero;
  logic       mem_ready;
  logic       pc_write, ir_write, reg_write, mem_write, adr_src, illegal_op;
  logic [1:0] alu_src_a, alu_src_b, result_src, imm_src;
  logic [2:0] alu_control;

  mc_control_fsm dut (
    .clk(clk), .rst_n(rst_n), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .zero(zero), .mem_ready(mem_ready), .pc_write(pc_write), .ir_write(ir_write),
    .reg_write(reg_write), .mem_write(mem_write), .adr_src(adr_src),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .result_src(result_src),
    .imm_src(imm_src), .alu_control(alu_control), .illegal_op(illegal_op)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [16:0] outs;
  assign outs = {pc_write, ir_write, reg_write, mem_write, adr_src, alu_src_a,
                 alu_src_b, result_src, imm_src, alu_control, illegal_op};

  int checks = 0;
  int errors = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // One expected cycle of an instruction; pcm: 0 low, 1 high, 2 =mem_ready, 3 =zero^funct3[0]
  typedef struct {
    logic [1:0] a, b, rs, pcm;
    logic       adr, rw, mw, ill, irm, waits;
    logic [2:0] alu;
  } step_t;

  step_t      q[$];
  logic [1:0] cur_imm;
  int         cur_cls;

  function automatic step_t blank();
    step_t s;
    s = '{default: '0};
    return s;
  endfunction

  function automatic logic [2:0] ref_alu(input logic [2:0] f3, input logic f7, input bit is_r);
    case (f3)
      3'b000:  return (is_r && f7) ? 3'd1 : 3'd0;
      3'b010:  return 3'd5;
      3'b110:  return 3'd3;
      3'b111:  return 3'd2;
      default: return 3'd0;
    endcase
  endfunction

  function automatic bit known_op(input logic [6:0] o);
    return o == 7'b0000011 || o == 7'b0100011 || o == 7'b0110011 ||
           o == 7'b0010011 || o == 7'b1100011 || o == 7'b1101111;
  endfunction

  // classes: 0 lw, 1 sw, 2 R, 3 I-ALU, 4 branch, 5 jal, 6 unknown op, 7 bad branch funct3
  task automatic new_instr();
    step_t s;
    int    guard;
    cur_cls  = $urandom_range(0, 7);
    funct3   = 3'($urandom);
    funct7b5 = 1'($urandom);
    case (cur_cls)
      0: op = 7'b0000011;
      1: op = 7'b0100011;
      2: op = 7'b0110011;
      3: op = 7'b0010011;
      4: begin op = 7'b1100011; funct3 = {2'b00, 1'($urandom)}; end
      5: op = 7'b1101111;
      6: begin
        op = 7'($urandom);
        guard = 0;
        while (known_op(op) && guard < 50) begin op = 7'($urandom); guard++; end
        if (known_op(op)) op = 7'b1111111;
      end
      default: begin op = 7'b1100011; funct3 = 3'($urandom_range(2, 7)); end
    endcase
    cur_imm = (cur_cls == 1) ? 2'd1 : (cur_cls == 4 || cur_cls == 7) ? 2'd2 :
              (cur_cls == 5) ? 2'd3 : 2'd0;

    s = blank(); s.b = 2; s.rs = 2; s.pcm = 2; s.irm = 1; s.waits = 1; q.push_back(s);
    s = blank(); s.a = 1; s.b = 1; s.ill = (cur_cls >= 6); q.push_back(s);
    case (cur_cls)
      0: begin
        s = blank(); s.a = 2; s.b = 1; q.push_back(s);
        s = blank(); s.adr = 1; s.waits = 1; q.push_back(s);
        s = blank(); s.rs = 1; s.rw = 1; q.push_back(s);
      end
      1: begin
        s = blank(); s.a = 2; s.b = 1; q.push_back(s);
        s = blank(); s.adr = 1; s.mw = 1; s.waits = 1; q.push_back(s);
      end
      2, 3: begin
        s = blank(); s.a = 2; s.b = (cur_cls == 3) ? 2'd1 : 2'd0;
        s.alu = ref_alu(funct3, funct7b5, cur_cls == 2); q.push_back(s);
        s = blank(); s.rw = 1; q.push_back(s);
      end
      4: begin
        s = blank(); s.a = 2; s.alu = 3'd1; s.pcm = 3; q.push_back(s);
      end
      5: begin
        s = blank(); s.a = 1; s.b = 2; s.pcm = 1; q.push_back(s);
        s = blank(); s.rw = 1; q.push_back(s);
      end
      default: ;
    endcase
  endtask

  function automatic logic [16:0] expect_of(input step_t s);
    logic pc;
    case (s.pcm)
      2'd0:    pc = 1'b0;
      2'd1:    pc = 1'b1;
      2'd2:    pc = mem_ready;
      default: pc = zero ^ funct3[0];
    endcase
    return {pc, s.irm & mem_ready, s.rw, s.mw, s.adr, s.a, s.b, s.rs, cur_imm, s.alu, s.ill};
  endfunction

  step_t popped;

  initial begin
    rst_n = 1'b0; op = 7'b0100011; funct3 = 3'b010; funct7b5 = 1'b0;
    zero = 1'b0; mem_ready = 1'b1;
    repeat (2) @(negedge clk);
    check_val("reset_outs", 32'(outs), 32'({13'd0, 2'b01, 3'd0, 1'b0}));

    // sw with a stalled MEMWRITE, then reset lands in the middle of it
    rst_n = 1'b1;
    #1 check_val("fetch_ir_pc", 32'({ir_write, pc_write}), 32'd3);
    @(negedge clk);
    #1 check_val("decode_a_imm", 32'({alu_src_a, imm_src}), 32'({2'b01, 2'b01}));
    @(negedge clk);
    #1 check_val("memadr_a_b", 32'({alu_src_a, alu_src_b}), 32'({2'b10, 2'b01}));
    @(negedge clk); mem_ready = 1'b0;
    #1 check_val("memwrite_strb", 32'({mem_write, adr_src}), 32'd3);
    @(negedge clk);
    #1 check_val("memwrite_stall", 32'({mem_write, adr_src}), 32'd3);
    #2 rst_n = 1'b0;
    #1 check_val("rst_kills_write", 32'(mem_write), 32'd0);
    check_val("rst_mid_outs", 32'(outs), 32'({13'd0, 2'b01, 3'd0, 1'b0}));
    @(negedge clk); rst_n = 1'b1; mem_ready = 1'b1;
    #1 check_val("release_fetch", 32'({ir_write, pc_write, alu_src_b}), 32'({2'b11, 2'b10}));
    @(negedge clk);
    #1 check_val("release_decode", 32'(alu_src_a), 32'd1);
    rst_n = 1'b0;

    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(negedge clk);
      if (rst_n == 1'b0) begin
        rst_n = 1'b1;
        q.delete();
      end
      mem_ready = ($urandom_range(0, 3) != 0);
      zero      = 1'($urandom);
      if (q.size() == 0) new_instr();
      if ($urandom_range(0, 149) == 0) begin
        rst_n = 1'b0;
        #1 check_val("rand_reset", 32'(outs), 32'({13'd0, cur_imm, 3'd0, 1'b0}));
      end else begin
        #1 check_val($sformatf("cls%0d_step", cur_cls), 32'(outs), 32'(expect_of(q[0])));
        if (!(q[0].waits && !mem_ready)) popped = q.pop_front();
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
